// File: rtl/add_accum.sv
// add_accum: frame accumulator for the adder's {co, sum} output.
// Words are summed into a widened unsigned accumulator. A frame closes
// after FRAME_LEN words, or earlier on flush. The frame total, word count
// and sticky overflow flag are then held until the consumer takes them.
module add_accum #(
    parameter  int DATA_WIDTH = 32,
    parameter  int FRAME_LEN  = 8,
    parameter  int EXT_BITS   = 4,
    localparam int ACC_WIDTH  = DATA_WIDTH + 1 + EXT_BITS,
    localparam int CNT_WIDTH  = $clog2(FRAME_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_sum,
    input  logic                  in_co,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_ovf
);

    typedef enum logic {
        ST_ACC,
        ST_DONE
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   ovf;

    logic                   accept;
    logic [ACC_WIDTH-1:0]   operand;
    logic [ACC_WIDTH:0]     sum_full;
    logic [CNT_WIDTH-1:0]   cnt_post;
    logic                   close_frame;

    // Handshake flags come straight from the state register, so there is
    // no combinational path from in_valid/out_ready to in_ready/out_valid.
    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_DONE);
    assign out_data  = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

    assign accept  = in_valid & in_ready;
    // Zero-extension written as a size cast so EXT_BITS = 0 stays legal.
    assign operand = ACC_WIDTH'({in_co, in_sum});

    // Next-value datapath: one widened add whose top bit is the carry-out,
    // plus the count the frame will hold after this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        sum_full    = '0;
        cnt_post    = cnt;
        close_frame = 1'b0;
        sum_full    = {1'b0, acc} + {1'b0, operand};
        if (accept) begin
            cnt_post = cnt + CNT_WIDTH'(1);
        end
        if (state == ST_ACC) begin
            close_frame = (accept && (cnt_post == CNT_WIDTH'(FRAME_LEN))) ||
                          (flush && (cnt_post != '0));
        end
    end

    // Frame state machine: accumulate in ACC, hold the result in DONE.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc <= sum_full[ACC_WIDTH-1:0];
                        ovf <= ovf | sum_full[ACC_WIDTH];
                    end
                    cnt <= cnt_post;
                    if (close_frame) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        state <= ST_ACC;
                    end
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: doc/add_accum.md
# add_accum

Downstream accumulation stage for the multi-bit adder output. It takes the adder's `{co, sum}` result one word per handshake and sums words into a widened accumulator. It closes a frame after `FRAME_LEN` words, or earlier on a flush request, then presents the frame total together with the word count and a sticky overflow flag. It sits between the adder datapath and the result consumer, with valid/ready on both sides.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of the upstream `sum` word; ≥ 2.
- `FRAME_LEN`, default 8: words per full frame; ≥ 2.
- `EXT_BITS`, default 4: guard bits above the carry bit. Overflow is impossible when `EXT_BITS ≥ clog2(FRAME_LEN)`.
- Derived `ACC_WIDTH` = `DATA_WIDTH + 1 + EXT_BITS`.
- Derived `CNT_WIDTH` = `clog2(FRAME_LEN+1)`.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: upstream word present.
- `in_ready`, output, 1: block can accept a word.
- `in_sum`, input, `DATA_WIDTH`: adder `sum`.
- `in_co`, input, 1: adder carry-out; forms bit `DATA_WIDTH` of the operand.
- `flush`, input, 1: close the current frame early. Level-sampled, single-cycle effect.
- `out_valid`, output, 1: frame result present.
- `out_ready`, input, 1: downstream accepts the result.
- `out_data`, output, `ACC_WIDTH`: frame total, modulo 2^`ACC_WIDTH`.
- `out_count`, output, `CNT_WIDTH`: number of words in the frame, 1..`FRAME_LEN`.
- `out_ovf`, output, 1: sticky overflow; some addition in this frame carried out of `ACC_WIDTH`.

## Operation
- Operand = zero-extension of `{in_co, in_sum}` to `ACC_WIDTH`. The accumulator is unsigned.
- Accept = `in_valid & in_ready`. Output handshake = `out_valid & out_ready`.

State machine:
- **ACC**
  - `in_ready`=1, `out_valid`=0.
  - On accept: `acc <= acc + operand`, `cnt <= cnt+1`, `ovf <= ovf | carry_out(ACC_WIDTH)`.
  - Go to DONE when the accept makes `cnt` reach `FRAME_LEN`.
  - Also go to DONE when `flush`=1 and the post-update count ≥ 1. Flush in the same cycle as an accept includes that word.
  - Flush with count 0 and no accept is ignored; state stays ACC.
- **DONE**
  - `in_ready`=0, `out_valid`=1.
  - `out_data`, `out_count` and `out_ovf` hold stable until the output handshake.
  - `flush` is ignored.
  - On handshake: `acc`, `cnt` and `ovf` clear to 0, next state is ACC.
  - Without `out_ready`, stays in DONE indefinitely; no input is taken and no output changes.
- Outputs are driven directly from registers: `out_data`=`acc`, `out_count`=`cnt`, `out_ovf`=`ovf`. They are visible, but only meaningful, while `out_valid`=1.
- Wrap-around: on overflow the total keeps the low `ACC_WIDTH` bits and `ovf` sets. `ovf` never clears within a frame.
- Reset overrides everything, including a handshake in the same cycle.
  - Reset values: state ACC, `acc`=0, `cnt`=0, `ovf`=0, `out_valid`=0, `out_data`=0, `out_count`=0, `out_ovf`=0, `in_ready`=1 (from the cycle after `rst` deasserts; held 1 during reset as well).
  - A partial frame in progress at reset is discarded.

## Timing
- `in_ready` and `out_valid` are pure functions of state. There is no combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.
- Result latency: `out_valid` rises the cycle after the closing accept or flush.
- The first accept of the next frame is possible the cycle after the output handshake.
- Full-frame throughput: `FRAME_LEN` + 1 cycles minimum, with the output handshake taken in the first DONE cycle.
- Back-to-back accepts every cycle while in ACC.
- Adder is one `ACC_WIDTH`-bit add per cycle; there is no internal pipeline.

## Test plan
- **Full frame**: defaults, 8 accepts of `{co=0, sum=1}`, `out_ready`=1.
  - Expect `out_valid` the cycle after the 8th accept, with `out_data`=8, `out_count`=8, `out_ovf`=0.
  - Expect `in_ready`=1 the next cycle.
- **Carry input**: 2 accepts of `{co=1, sum=32'hFFFF_FFFF}` then flush.
  - Expect `out_data`=37'h3_FFFF_FFFE, `out_count`=2, `out_ovf`=0.
- **Overflow**: `EXT_BITS`=0, `DATA_WIDTH`=4, `FRAME_LEN`=2, operands 5'h1F and 5'h02.
  - Expect `out_data`=5'h01, `out_ovf`=1.
  - Expect the next frame to start with `ovf`=0.
- **Flush boundaries**:
  - Flush with count 0 → no `out_valid`.
  - Flush coincident with the 3rd accept of value 1 → `out_count`=3, `out_data`=3.
  - Flush in DONE → no effect.
- **Backpressure**: hold `out_ready`=0 for 10 cycles in DONE with `in_valid`=1.
  - Expect `in_ready`=0 throughout and the output stable.
  - Release → handshake, then the next frame accepts.
- **Reset mid-frame**: 5 accepts, then `rst` for 1 cycle.
  - Expect all outputs 0 and `in_ready`=1.
  - A subsequent 8-word frame of value 2 gives `out_data`=16.
